// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// opcode encodings, FSM states, HI/LO write-enable levels and opcode class helpers.
package mdu_iter_pkg;

    localparam logic [3:0] MD_NO    = 4'd0;
    localparam logic [3:0] MD_MUL   = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_MADD  = 4'd3;
    localparam logic [3:0] MD_MADDU = 4'd4;
    localparam logic [3:0] MD_MSUB  = 4'd5;
    localparam logic [3:0] MD_MSUBU = 4'd6;
    localparam logic [3:0] MD_DIV   = 4'd7;
    localparam logic [3:0] MD_DIVU  = 4'd8;
    localparam logic [3:0] MD_MTHI  = 4'd9;
    localparam logic [3:0] MD_MTLO  = 4'd10;

    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } mdu_state_t;

    // Ops that need the iterative datapath (everything from MUL to DIVU).
    function automatic logic md_is_multicycle(input logic [3:0] op);
        return (op >= MD_MUL) && (op <= MD_DIVU);
    endfunction

    function automatic logic md_is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_signed(input logic [3:0] op);
        return (op == MD_MUL) || (op == MD_MADD) || (op == MD_MSUB) || (op == MD_DIV);
    endfunction

    function automatic logic md_is_acc(input logic [3:0] op);
        return (op >= MD_MADD) && (op <= MD_MSUBU);
    endfunction

    function automatic logic md_is_sub(input logic [3:0] op);
        return (op == MD_MSUB) || (op == MD_MSUBU);
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// One iteration of the shared magnitude datapath.
// Multiply: {hi,lo} holds {partial product, remaining multiplier}; add-then-shift-right.
// Divide:   {hi,lo} holds {remainder, dividend/quotient}; shift-left-then-trial-subtract
//           (restoring). A single WIDTH+2 adder serves both.
module mdu_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_a;
    logic [WIDTH+1:0] w_b;
    logic [WIDTH+1:0] w_sum;
    logic             w_cin;
    logic             w_neg;

    // Operand select, shared add/subtract, and result steering for one step.
    always_comb begin
        w_shift = {i_hi, i_lo[WIDTH-1]};
        if (i_div) begin
            w_a   = {1'b0, w_shift};
            w_b   = ~{2'b00, i_opnd};
            w_cin = 1'b1;
        end else begin
            w_a   = {2'b00, i_hi};
            w_b   = {2'b00, {WIDTH{i_lo[0]}} & i_opnd};
            w_cin = 1'b0;
        end
        w_sum = w_a + w_b + {{(WIDTH+1){1'b0}}, w_cin};
        w_neg = w_sum[WIDTH+1];
        if (i_div) begin
            // negative trial result: restore (keep the shifted remainder)
            o_hi = w_neg ? w_shift[WIDTH-1:0] : w_sum[WIDTH-1:0];
            o_lo = {i_lo[WIDTH-2:0], ~w_neg};
        end else begin
            o_hi = w_sum[WIDTH:1];
            o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit for the EX stage.
//   state | meaning
//   IDLE  | waiting; MTHI/MTLO complete here; multicycle ops latch operands
//   CALC  | one shift/add or shift/subtract iteration per cycle, WIDTH cycles
//   FIX   | apply result signs and accumulate into the HI/LO base
//   DONE  | present result, write HI/LO, release the stall
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           op_i,
    input  logic [WIDTH-1:0]     rdata1_i,
    input  logic [WIDTH-1:0]     rdata2_i,
    input  logic                 flush_i,
    input  logic [WIDTH-1:0]     hi_i,
    input  logic [WIDTH-1:0]     lo_i,
    input  logic                 mem_whilo_i,
    input  logic [WIDTH-1:0]     mem_hi_i,
    input  logic [WIDTH-1:0]     mem_lo_i,
    input  logic                 wb_whilo_i,
    input  logic [WIDTH-1:0]     wb_hi_i,
    input  logic [WIDTH-1:0]     wb_lo_i,
    output logic [WIDTH-1:0]     hi_fwd_o,
    output logic [WIDTH-1:0]     lo_fwd_o,
    output logic [WIDTH-1:0]     hi_o,
    output logic [WIDTH-1:0]     lo_o,
    output logic                 whilo_o,
    output logic [2*WIDTH-1:0]   mul_out_o,
    output logic                 stallreq_o
);

    mdu_state_t         r_state;
    mdu_state_t         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [2*WIDTH-1:0] r_base;
    logic [2*WIDTH-1:0] r_res;
    logic [2*WIDTH-1:0] r_prod;

    logic               w_sign1;
    logic               w_sign2;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic               w_start;
    logic               w_div0;
    logic               w_r_is_div;
    logic [WIDTH-1:0]   w_core_hi;
    logic [WIDTH-1:0]   w_core_lo;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_quot_s;
    logic [WIDTH-1:0]   w_rem_s;
    logic [2*WIDTH-1:0] w_fix_res;

    assign hi_fwd_o = mem_whilo_i ? mem_hi_i : (wb_whilo_i ? wb_hi_i : hi_i);
    assign lo_fwd_o = mem_whilo_i ? mem_lo_i : (wb_whilo_i ? wb_lo_i : lo_i);

    assign w_start = md_is_multicycle(op_i);
    assign w_div0  = md_is_div(op_i) && (rdata2_i == '0);
    assign w_sign1 = md_is_signed(op_i) & rdata1_i[WIDTH-1];
    assign w_sign2 = md_is_signed(op_i) & rdata2_i[WIDTH-1];
    assign w_mag1  = w_sign1 ? -rdata1_i : rdata1_i;
    assign w_mag2  = w_sign2 ? -rdata2_i : rdata2_i;

    assign w_r_is_div = md_is_div(r_op);

    mdu_iter_core #(.WIDTH(WIDTH)) u_core (
        .i_div  (w_r_is_div),
        .i_hi   (r_hi),
        .i_lo   (r_lo),
        .i_opnd (r_opnd),
        .o_hi   (w_core_hi),
        .o_lo   (w_core_lo)
    );

    // Sign fix-up and accumulate; MIN/-1 wraps naturally to MIN with remainder 0.
    always_comb begin
        w_prod_s = r_neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};
        w_quot_s = r_neg_q ? -r_lo : r_lo;
        w_rem_s  = r_neg_r ? -r_hi : r_hi;
        if (w_r_is_div) begin
            w_fix_res = {w_rem_s, w_quot_s};
        end else if (md_is_acc(r_op)) begin
            w_fix_res = md_is_sub(r_op) ? (r_base - w_prod_s) : (r_base + w_prod_s);
        end else begin
            w_fix_res = w_prod_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and outputs; flush overrides everything, including a new op.
    always_comb begin
        w_state_nxt = r_state;
        hi_o        = '0;
        lo_o        = '0;
        whilo_o     = WriteDisable;
        mul_out_o   = '0;
        stallreq_o  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (op_i == MD_MTHI) begin
                    hi_o    = rdata1_i;
                    lo_o    = lo_fwd_o;
                    whilo_o = WriteEnable;
                end else if (op_i == MD_MTLO) begin
                    hi_o    = hi_fwd_o;
                    lo_o    = rdata1_i;
                    whilo_o = WriteEnable;
                end else if (w_start) begin
                    stallreq_o  = 1'b1;
                    w_state_nxt = w_div0 ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                stallreq_o = 1'b1;
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                stallreq_o  = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                hi_o        = r_res[2*WIDTH-1:WIDTH];
                lo_o        = r_res[WIDTH-1:0];
                whilo_o     = WriteEnable;
                mul_out_o   = r_prod;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush_i) begin
            w_state_nxt = S_IDLE;
            whilo_o     = WriteDisable;
            stallreq_o  = 1'b0;
        end
    end

    // Operand capture, iteration and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_op    <= MD_NO;
            r_hi    <= '0;
            r_lo    <= '0;
            r_opnd  <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_base  <= '0;
            r_res   <= '0;
            r_prod  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_op    <= op_i;
                        r_cnt   <= '0;
                        r_hi    <= '0;
                        r_lo    <= w_mag1;
                        r_opnd  <= w_mag2;
                        r_neg_q <= w_sign1 ^ w_sign2;
                        r_neg_r <= w_sign1;
                        r_base  <= {hi_fwd_o, lo_fwd_o};
                        // divide-by-zero result, used only when skipping straight to DONE
                        r_res   <= {rdata1_i, {WIDTH{1'b1}}};
                        r_prod  <= '0;
                    end
                end
                S_CALC: begin
                    r_hi  <= w_core_hi;
                    r_lo  <= w_core_lo;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_FIX: begin
                    r_res  <= w_fix_res;
                    r_prod <= w_r_is_div ? '0 : w_prod_s;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: the driver pushes reference results, the monitor
// pops one entry each time the DUT writes HI/LO and compares result and stall length.
module tb_mdu_iter;
    import mdu_iter_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [63:0] prod;
        int          stalls;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [3:0]    op_i = MD_NO;
    logic [31:0]   rdata1_i = '0, rdata2_i = '0;
    logic          flush_i = 1'b0;
    logic [31:0]   hi_i = '0, lo_i = '0;
    logic          mem_whilo_i = 1'b0, wb_whilo_i = 1'b0;
    logic [31:0]   mem_hi_i = '0, mem_lo_i = '0, wb_hi_i = '0, wb_lo_i = '0;
    logic [31:0]   hi_fwd_o, lo_fwd_o, hi_o, lo_o;
    logic          whilo_o, stallreq_o;
    logic [63:0]   mul_out_o;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .op_i(op_i), .rdata1_i(rdata1_i), .rdata2_i(rdata2_i),
        .flush_i(flush_i), .hi_i(hi_i), .lo_i(lo_i),
        .mem_whilo_i(mem_whilo_i), .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i),
        .wb_whilo_i(wb_whilo_i), .wb_hi_i(wb_hi_i), .wb_lo_i(wb_lo_i),
        .hi_fwd_o(hi_fwd_o), .lo_fwd_o(lo_fwd_o), .hi_o(hi_o), .lo_o(lo_o),
        .whilo_o(whilo_o), .mul_out_o(mul_out_o), .stallreq_o(stallreq_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: plain signed/unsigned arithmetic on 64-bit integers.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] base, output exp_t e);
        longint sa, sb, q, r;
        logic [63:0] p, full;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.op = op; e.prod = '0; e.stalls = W + 2; p = '0; full = '0;
        case (op)
            MD_MUL, MD_MADD, MD_MSUB:    p = 64'(sa * sb);
            MD_MULTU, MD_MADDU, MD_MSUBU: p = {32'b0, a} * {32'b0, b};
            default: p = '0;
        endcase
        case (op)
            MD_MUL, MD_MULTU: full = p;
            MD_MADD, MD_MADDU: full = base + p;
            MD_MSUB, MD_MSUBU: full = base - p;
            MD_DIV: begin
                if (b == 0) begin full = {a, 32'hFFFF_FFFF}; e.stalls = 1; end
                else begin q = sa / sb; r = sa % sb; full = {32'(r), 32'(q)}; end
            end
            MD_DIVU: begin
                if (b == 0) begin full = {a, 32'hFFFF_FFFF}; e.stalls = 1; end
                else full = {a % b, a / b};
            end
            MD_MTHI: begin full = {a, base[31:0]}; e.stalls = 0; end
            MD_MTLO: begin full = {base[63:32], a}; e.stalls = 0; end
            default: full = '0;
        endcase
        if (!md_is_div(op)) e.prod = p;
        e.hi = full[63:32];
        e.lo = full[31:0];
    endtask

    // Call at posedge+1: issue one op, hold it until the DUT releases the stall.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] base;
        exp_t e;
        bit done;
        base = mem_whilo_i ? {mem_hi_i, mem_lo_i} :
               wb_whilo_i  ? {wb_hi_i, wb_lo_i}   : {hi_i, lo_i};
        model(op, a, b, base, e);
        sb_q.push_back(e);
        op_i = op; rdata1_i = a; rdata2_i = b;
        #1;
        check("hi_fwd", {32'b0, hi_fwd_o}, {32'b0, base[63:32]});
        check("lo_fwd", {32'b0, lo_fwd_o}, {32'b0, base[31:0]});
        done = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (!stallreq_o) done = 1;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL stall_timeout: op %0d still stalling after 100 cycles", op);
        end
        @(posedge clk); #1;
        op_i = MD_NO;
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    // Monitor: every HI/LO write must match the oldest expectation.
    initial begin
        int   stall_cnt;
        exp_t e;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                stall_cnt = 0;
            end else if (whilo_o) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_whilo: hi=%h lo=%h with no op outstanding", hi_o, lo_o);
                end else begin
                    e = sb_q.pop_front();
                    check("hi_o", {32'b0, hi_o}, {32'b0, e.hi});
                    check("lo_o", {32'b0, lo_o}, {32'b0, e.lo});
                    check("mul_out", mul_out_o, e.prod);
                    check("stall_cycles", 64'(stall_cnt), 64'(e.stalls));
                end
                stall_cnt = 0;
            end else if (stallreq_o) begin
                stall_cnt++;
            end else begin
                stall_cnt = 0;
            end
        end
    end

    // Stimulus.
    initial begin
        #2;
        check("rst_hi_o", {32'b0, hi_o}, 64'h0);
        check("rst_lo_o", {32'b0, lo_o}, 64'h0);
        check("rst_whilo", {63'b0, whilo_o}, 64'h0);
        check("rst_stall", {63'b0, stallreq_o}, 64'h0);
        check("rst_mul_out", mul_out_o, 64'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(MD_MUL, 32'hFFFF_FFF9, 32'd3);
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        issue(MD_DIVU, 32'd100, 32'd0);
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);

        hi_i = 32'h77; lo_i = 32'h88;
        wb_whilo_i = 1'b1; wb_hi_i = 32'h55; wb_lo_i = 32'h66;
        mem_whilo_i = 1'b1; mem_hi_i = 32'h0; mem_lo_i = 32'hFFFF_FFFE;
        issue(MD_MADD, 32'd2, 32'd3);
        mem_whilo_i = 1'b0;
        issue(MD_MSUBU, 32'd5, 32'd7);
        issue(MD_MTHI, 32'h1234, 32'h0);
        wb_whilo_i = 1'b0;
        issue(MD_MTLO, 32'hABCD, 32'h0);

        // flush in CALC cycle 10 of a DIV: no HI/LO write, stall drops at once
        op_i = MD_DIV; rdata1_i = 32'hFFFF_FF9C; rdata2_i = 32'd7;
        repeat (10) @(posedge clk);
        #1 flush_i = 1'b1;
        #1;
        check("flush_stall", {63'b0, stallreq_o}, 64'h0);
        check("flush_whilo", {63'b0, whilo_o}, 64'h0);
        @(posedge clk); #1;
        flush_i = 1'b0; op_i = MD_NO;
        #1;
        check("post_flush_stall", {63'b0, stallreq_o}, 64'h0);
        @(posedge clk); #1;

        // asynchronous reset in the middle of a MULTU
        op_i = MD_MULTU; rdata1_i = 32'h1234_5678; rdata2_i = 32'h9ABC_DEF0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0; op_i = MD_NO;
        #1;
        check("midrst_hi_o", {32'b0, hi_o}, 64'h0);
        check("midrst_lo_o", {32'b0, lo_o}, 64'h0);
        check("midrst_whilo", {63'b0, whilo_o}, 64'h0);
        check("midrst_stall", {63'b0, stallreq_o}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        issue(MD_DIVU, 32'd9, 32'd4);

        for (int n = 0; n < 40; n++) begin
            mem_whilo_i = 1'($urandom_range(0, 1));
            wb_whilo_i  = 1'($urandom_range(0, 1));
            mem_hi_i = $urandom(); mem_lo_i = $urandom();
            wb_hi_i  = $urandom(); wb_lo_i  = $urandom();
            hi_i     = $urandom(); lo_i     = $urandom();
            issue(4'($urandom_range(1, 10)), rnd_opnd(), rnd_opnd());
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit for the EX stage; next generation of the fixed 32-bit MDU.
- Handles signed/unsigned multiply, multiply-accumulate (MADD/MADDU/MSUB/MSUBU) and signed/unsigned divide, at one bit per cycle.
- Handles MTHI/MTLO in a single cycle.
- Owns HI/LO forwarding (mem > wb > register file), drives stallreq to the pipeline controller, and supports flush abort.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- op_i  in  4  MD_NO/MUL/MULTU/MADD/MADDU/MSUB/MSUBU/DIV/DIVU/MTHI/MTLO
- rdata1_i  in  WIDTH  rs operand
- rdata2_i  in  WIDTH  rt operand
- flush_i  in  1  abort current operation
- hi_i, lo_i  in  WIDTH each  register-file HI/LO
- mem_whilo_i  in  1  mem-stage HI/LO write enable
- mem_hi_i, mem_lo_i  in  WIDTH each  mem-stage HI/LO values
- wb_whilo_i  in  1  wb-stage HI/LO write enable
- wb_hi_i, wb_lo_i  in  WIDTH each  wb-stage HI/LO values
- hi_fwd_o, lo_fwd_o  out  WIDTH each  forwarded HI/LO (for MFHI/MFLO)
- hi_o, lo_o  out  WIDTH each  result to write into HI/LO
- whilo_o  out  1  HI/LO write enable, to the mem stage
- mul_out_o  out  2*WIDTH  full product (low half feeds the GPR for MUL)
- stallreq_o  out  1  hold the pipeline

Behaviour:
- Forwarding (combinational):
  - hi_fwd_o = mem_whilo_i ? mem_hi_i : wb_whilo_i ? wb_hi_i : hi_i; lo_fwd_o uses the same priority.
- States: IDLE, CALC, FIX, DONE. Reset puts the FSM in IDLE with counter, accumulator and all registered outputs at 0.
- IDLE:
  - MD_NO: outputs 0, stallreq_o=0.
  - MTHI: hi_o=rdata1_i, lo_o=lo_fwd_o, whilo_o=1, no stall. MTLO is symmetric.
  - Multicycle op present: stallreq_o=1 combinationally. Latch operand magnitudes, sign flags, op and forwarded HI/LO (accumulate base); counter=0; go to CALC.
- CALC, one iteration per cycle:
  - Multiply: shift-add.
  - Divide: restoring; remainder and quotient are WIDTH bits each.
  - After WIDTH iterations go to FIX. stallreq_o=1.
- FIX, one cycle:
  - Apply signs: product negative iff the signs differ; quotient negative iff the signs differ; remainder takes the dividend's sign.
  - Accumulate ops add or subtract the 2*WIDTH result to/from {HI,LO} base, modulo 2^(2*WIDTH).
  - stallreq_o=1; go to DONE.
- DONE:
  - stallreq_o=0, whilo_o=1.
  - hi_o/lo_o = {product high, product low}, or {remainder, quotient} for divide.
  - mul_out_o holds the product.
  - Next state IDLE. The pipeline advances on this edge, so the op is never re-triggered.
- Latency: stallreq_o high for WIDTH+2 cycles; results valid in cycle WIDTH+2 counting the issue cycle as 0 (34 stall cycles at WIDTH=32).
- Divide by zero: IDLE goes directly to DONE (1 stall cycle). Quotient = all ones; remainder = dividend.
- Signed MIN/-1: quotient=MIN, remainder=0, no trap; this falls out of the magnitude datapath and needs no special case.
- flush_i: in any state the next state is IDLE with whilo_o=0 and stallreq_o=0 combinationally. Flush has priority over a simultaneous new op.
- whilo_o is 0 in IDLE for multicycle ops and in CALC/FIX; it is only 1 for MTHI/MTLO and in DONE.
- Reset asserted mid-operation returns the FSM to IDLE asynchronously; HI/LO are not written.

Decomposition:
- Shared package/include: MD_* opcode constants, state encodings, WriteEnable/WriteDisable.
- One natural sub-module, mdu_iter_core: the shared shift/add-subtract datapath (WIDTH-parametrised) used by both multiply and divide.
- FSM, forwarding and sign fix stay in mdu_iter.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, WIDTH=32 -> stallreq_o high 34 cycles; DONE hi_o=0xFFFFFFFE, lo_o=0x00000001, whilo_o=1.
- MUL -7 × 3 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB; then DIV -7 / 2 -> lo_o=0xFFFFFFFD (-3), hi_o=0xFFFFFFFF (-1).
- DIVU 100 / 0 -> 1 stall cycle; lo_o=0xFFFFFFFF, hi_o=100. DIV 0x80000000 / -1 -> lo_o=0x80000000, hi_o=0.
- MADD 2 × 3 with mem_whilo_i=1, mem_hi_i=0, mem_lo_i=0xFFFFFFFE -> hi_o=1, lo_o=4, proving mem-stage forwarding priority over wb/regfile.
- MTHI 0x1234 -> whilo_o=1 same cycle, hi_o=0x1234, no stall. Separately, flush_i pulsed in CALC cycle 10 of a DIV -> IDLE next cycle, whilo_o never 1, stallreq_o=0.
- Reset (rst=0) mid-MULTU -> outputs 0 immediately; after release, a fresh DIVU 9/4 gives lo_o=2, hi_o=1.
